// File: rtl/cordic_vectoring.sv
// cordic_vectoring: folded vectoring-mode CORDIC returning atan(y/x) and K-scaled magnitude
module cordic_vectoring #(
  parameter int FRACS = 21,
  parameter int INTS = 1,
  parameter int WIDTH = INTS + FRACS + 1,
  parameter int ITERATIONS = 15,
  parameter int ITERS_PER_CYCLE = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] fixedPoint_x,
  input  logic signed [WIDTH-1:0] fixedPoint_y,
  output logic                    busy,
  output logic                    done,
  output logic                    range_err,
  output logic signed [WIDTH-1:0] fixedPoint_angle,
  output logic signed [WIDTH-1:0] fixedPoint_mag
);
  localparam int N = ITERATIONS / ITERS_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int IW = $clog2(ITERATIONS);
  localparam logic [WIDTH-1:0] ATAN [15] = '{
    WIDTH'(1647099), WIDTH'(972339), WIDTH'(513757), WIDTH'(260791), WIDTH'(130901),
    WIDTH'(65514), WIDTH'(32765), WIDTH'(16383), WIDTH'(8191), WIDTH'(4095),
    WIDTH'(2047), WIDTH'(1023), WIDTH'(511), WIDTH'(255), WIDTH'(127)
  };
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic signed [WIDTH-1:0] x, y, z;
  logic err;
  logic signed [WIDTH-1:0] xs [ITERS_PER_CYCLE+1];
  logic signed [WIDTH-1:0] ys [ITERS_PER_CYCLE+1];
  logic signed [WIDTH-1:0] zs [ITERS_PER_CYCLE+1];
  logic last, accept, fin;
  assign last = cnt == CW'(N - 1);
  assign busy = state == RUN;
  assign accept = state == IDLE && start;
  assign fin = state == RUN && last;
  assign xs[0] = x;
  assign ys[0] = y;
  assign zs[0] = z;
  for (genvar j = 0; j < ITERS_PER_CYCLE; j++) begin : g_it
    logic [IW-1:0] i;
    logic neg;
    assign i = IW'(cnt) * IW'(ITERS_PER_CYCLE) + IW'(j);
    assign neg = ys[j][WIDTH-1];
    assign xs[j+1] = neg ? xs[j] - (ys[j] >>> i) : xs[j] + (ys[j] >>> i);
    assign ys[j+1] = neg ? ys[j] + (xs[j] >>> i) : ys[j] - (xs[j] >>> i);
    assign zs[j+1] = neg ? zs[j] - $signed(ATAN[i]) : zs[j] + $signed(ATAN[i]);
  end
  // state register; frozen while clk_en is low
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else if (clk_en) state <= state_nx;
  // start only matters in IDLE; RUN ends after the last folded step
  always_comb
    state_nx = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  // operand load, folded iteration steps and result capture
  always_ff @(posedge clk)
    if (!reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
      cnt <= '0;
      err <= 1'b0;
      done <= 1'b0;
      range_err <= 1'b0;
      fixedPoint_angle <= '0;
      fixedPoint_mag <= '0;
    end else if (clk_en) begin
      done <= fin;
      if (accept) begin
        x <= fixedPoint_x;
        y <= fixedPoint_y;
        z <= '0;
        cnt <= '0;
        err <= fixedPoint_x[WIDTH-1];
      end else if (state == RUN) begin
        x <= xs[ITERS_PER_CYCLE];
        y <= ys[ITERS_PER_CYCLE];
        z <= zs[ITERS_PER_CYCLE];
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (fin) begin
        range_err <= err;
        fixedPoint_angle <= err ? '0 : zs[ITERS_PER_CYCLE];
        fixedPoint_mag <= err ? '0 : xs[ITERS_PER_CYCLE];
      end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: randomized and directed checks against an iterative CORDIC reference
module tb_cordic_vectoring;
  localparam int W = 23;
  logic clk = 1'b0, reset = 1'b0, clk_en = 1'b1, start = 1'b0;
  logic signed [W-1:0] fx = '0, fy = '0;
  logic busy, done, range_err;
  logic signed [W-1:0] angle, mag;
  int n_pass = 0, n_total = 0;
  int atan_tab [15];

  always #5 clk = ~clk;

  cordic_vectoring dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .fixedPoint_x(fx), .fixedPoint_y(fy), .busy(busy), .done(done),
    .range_err(range_err), .fixedPoint_angle(angle), .fixedPoint_mag(mag)
  );

  function automatic void model(input logic signed [W-1:0] xi, yi,
                                output logic signed [W-1:0] a, m, output logic e);
    logic signed [W-1:0] x, y, z, xn, yn;
    x = xi; y = yi; z = '0;
    for (int i = 0; i < 15; i++) begin
      if (y >= 0) begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + W'(atan_tab[i]);
      end else begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - W'(atan_tab[i]);
      end
      x = xn; y = yn;
    end
    e = xi < 0;
    a = e ? '0 : z;
    m = e ? '0 : x;
  endfunction

  task automatic issue(input logic signed [W-1:0] x, y);
    @(negedge clk); fx = x; fy = y; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 40) begin @(negedge clk); edges++; end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, range_err, angle, mag} !== '0)
      $display("FAIL reset: busy=%b done=%b err=%b angle=%h mag=%h, want all 0", busy, done, range_err, angle, mag);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_directed(input string nm, input logic signed [W-1:0] x, y, input int ea, em);
    int e, da, dm;
    logic signed [W-1:0] ra, rm; logic re;
    model(x, y, ra, rm, re);
    issue(x, y); wait_done(e);
    da = int'(angle) - ea; dm = int'(mag) - em;
    n_total++;
    if (e !== 4) $display("FAIL %s latency: got %0d edges, want 4", nm, e); else n_pass++;
    n_total++;
    if (da < -256 || da > 256 || dm < -256 || dm > 256 || range_err !== 1'b0)
      $display("FAIL %s tolerance: angle=%0d mag=%0d err=%b, want %0d/%0d +-256 err=0", nm, angle, mag, range_err, ea, em);
    else n_pass++;
    n_total++;
    if ({range_err, angle, mag} !== {re, ra, rm})
      $display("FAIL %s exact: got %b/%h/%h, want %b/%h/%h", nm, range_err, angle, mag, re, ra, rm);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL %s pulse: done=%b after one cycle, want 0", nm, done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int e; logic hold_ok;
    logic signed [W-1:0] a1, m1, ra, rm; logic re;
    issue(W'(524288), W'(-524288)); wait_done(e);
    n_total++;
    if (int'(angle) < -1647099 - 256 || int'(angle) > -1647099 + 256 || int'(mag) < 1220993 - 256 || int'(mag) > 1220993 + 256)
      $display("FAIL neg45: angle=%0d mag=%0d, want -1647099/1220993 +-256", angle, mag);
    else n_pass++;
    a1 = angle; m1 = mag;
    model(W'(524288), W'(524288), ra, rm, re);
    fx = W'(524288); fy = W'(524288); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hold_ok = busy;
    e = 1;
    while (!done && e < 40) begin
      if (angle !== a1 || mag !== m1) hold_ok = 1'b0;
      @(negedge clk); e++;
    end
    n_total++;
    if (e !== 4 || !hold_ok) $display("FAIL b2b: latency=%0d hold_ok=%b, want 4/1", e, hold_ok); else n_pass++;
    n_total++;
    if ({range_err, angle, mag} !== {re, ra, rm})
      $display("FAIL b2b result: got %h/%h, want %h/%h", angle, mag, ra, rm);
    else n_pass++;
  endtask

  task automatic test_neg_x;
    int e;
    logic signed [W-1:0] ra, rm; logic re;
    issue(W'(-524288), W'(65536)); wait_done(e);
    n_total++;
    if ({done, range_err, angle, mag} !== {1'b1, 1'b1, 46'd0})
      $display("FAIL neg_x: done=%b err=%b angle=%h mag=%h, want 1/1/0/0", done, range_err, angle, mag);
    else n_pass++;
    model(W'(524288), W'(65536), ra, rm, re);
    issue(W'(524288), W'(65536)); wait_done(e);
    n_total++;
    if ({range_err, angle, mag} !== {re, ra, rm})
      $display("FAIL neg_x clear: got %b/%h/%h, want %b/%h/%h", range_err, angle, mag, re, ra, rm);
    else n_pass++;
  endtask

  task automatic test_busy_start;
    int e;
    logic signed [W-1:0] ra, rm; logic re;
    model(W'(300000), W'(-200000), ra, rm, re);
    issue(W'(300000), W'(-200000));
    @(negedge clk); fx = W'(100000); fy = W'(400000); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(e);
    n_total++;
    if (e + 2 !== 4 || {range_err, angle, mag} !== {re, ra, rm})
      $display("FAIL busy_start: latency=%0d got %h/%h, want 4 %h/%h", e + 2, angle, mag, ra, rm);
    else n_pass++;
  endtask

  task automatic test_clk_en;
    int e;
    logic signed [W-1:0] ra, rm; logic re;
    model(W'(-2000), W'(700000), ra, rm, re);
    model(W'(450000), W'(-350000), ra, rm, re);
    issue(W'(450000), W'(-350000));
    @(negedge clk); clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    wait_done(e);
    n_total++;
    if (e + 6 !== 9 || {range_err, angle, mag} !== {re, ra, rm})
      $display("FAIL clk_en: latency=%0d got %h/%h, want 9 %h/%h", e + 6, angle, mag, ra, rm);
    else n_pass++;
    clk_en = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (done !== 1'b1) $display("FAIL done_stretch: done=%b, want 1", done); else n_pass++;
    clk_en = 1'b1;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL done_release: done=%b, want 0", done); else n_pass++;
  endtask

  task automatic test_mid_reset;
    int e; logic seen;
    logic signed [W-1:0] ra, rm; logic re;
    issue(W'(400000), W'(250000));
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    n_total++;
    if ({busy, done, range_err, angle, mag} !== '0)
      $display("FAIL mid_reset: busy=%b done=%b err=%b angle=%h mag=%h, want all 0", busy, done, range_err, angle, mag);
    else n_pass++;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (done) seen = 1'b1; end
    n_total++;
    if (seen !== 1'b0) $display("FAIL mid_reset done: done seen=%b, want 0", seen); else n_pass++;
    model(W'(-300000), W'(-500000), ra, rm, re);
    model(W'(300000), W'(-500000), ra, rm, re);
    issue(W'(300000), W'(-500000)); wait_done(e);
    n_total++;
    if (e !== 4 || {range_err, angle, mag} !== {re, ra, rm})
      $display("FAIL after_reset: latency=%0d got %b/%h/%h, want 4 %b/%h/%h", e, range_err, angle, mag, re, ra, rm);
    else n_pass++;
  endtask

  task automatic test_random;
    int e, rx, ry;
    logic signed [W-1:0] ra, rm; logic re;
    for (int k = 0; k < 24; k++) begin
      rx = int'($urandom_range(0, 2097152)) - 1048576;
      ry = int'($urandom_range(0, 2097152)) - 1048576;
      model(W'(rx), W'(ry), ra, rm, re);
      issue(W'(rx), W'(ry)); wait_done(e);
      n_total++;
      if (e !== 4 || {range_err, angle, mag} !== {re, ra, rm})
        $display("FAIL random[%0d] x=%0d y=%0d: lat=%0d got %b/%h/%h, want 4 %b/%h/%h",
                 k, rx, ry, e, range_err, angle, mag, re, ra, rm);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 15; i++) atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * 2097152.0);
    test_reset;
    test_directed("zero_angle", W'(1048576), W'(0), 0, 1726743);
    test_directed("pos45", W'(524288), W'(524288), 1647099, 1220993);
    test_back_to_back;
    test_neg_x;
    test_busy_start;
    test_clk_en;
    test_mid_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Vectoring-mode CORDIC: the inverse direction of the rotation-mode `cordic` cosine block. Given a Cartesian vector (x, y) it drives y to zero and returns the angle atan(y/x) and the gain-scaled magnitude. It uses the same Q1.21 signed format and the same 15-entry arctangent table as the rotation core, and is folded over several cycles with a start/done handshake. It sits beside the rotation core as a custom-instruction datapath.

## Interface
- `FRACS`, 21, fractional bits
- `INTS`, 1, integer bits
- `WIDTH`, INTS+FRACS+1, total signed width (23)
- `ITERATIONS`, 15, CORDIC iterations
- `ITERS_PER_CYCLE`, 5, combinational iterations per clock; ITERATIONS must be a multiple of it; N = ITERATIONS/ITERS_PER_CYCLE (3)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clk`
- `clk_en`  in  1  when low, all registers hold their value
- `start`  in  1  request pulse; accepted only when `busy`=0
- `fixedPoint_x`  in  WIDTH  signed x; valid when `start`=1
- `fixedPoint_y`  in  WIDTH  signed y; valid when `start`=1
- `busy`  out  1  computation in progress
- `done`  out  1  one-cycle pulse; results valid
- `range_err`  out  1  registered with `done`; set when x < 0
- `fixedPoint_angle`  out  WIDTH  signed atan(y/x), in radians
- `fixedPoint_mag`  out  WIDTH  K·sqrt(x²+y²), where K ≈ 1.646760; no gain compensation is applied

## Operation
- **States:** IDLE, RUN.
  - IDLE→RUN on an accepted `start`.
  - RUN→IDLE when the cycle counter reaches N−1 on an enabled edge.
- **Load (accepting edge):** working registers take x←x_in, y←y_in, z←0. The counter is cleared.
- **Each enabled RUN edge:** applies ITERS_PER_CYCLE chained iterations, indices i = cnt·ITERS_PER_CYCLE + j.
  - If y ≥ 0: x' = x + (y>>>i), y' = y − (x>>>i), z' = z + atan_i.
  - If y < 0: x' = x − (y>>>i), y' = y + (x>>>i), z' = z − atan_i.
  - Every iteration j uses the x and y values from its predecessor, not from the register.
- **atan table:** atan(2^-i) in Q1.21, truncated, for i = 0..14. The table is bit-identical to the rotation core's table (e.g. i=0 → 0x1921FB).
- **Arithmetic:**
  - `>>>` is an arithmetic shift with truncation toward −∞.
  - All adds are WIDTH-bit two's-complement and wrap; there is no saturation.
  - Inputs are only guaranteed correct for |x|,|y| ≤ 0.5 (magnitude ≤ 1.165). Results are undefined but deterministic outside that range.
- **x < 0:** the input is latched and `range_err` is recorded at load. The iterations run normally. At completion, angle and magnitude outputs are forced to 0 and `range_err`=1.
- **Output registers:** `fixedPoint_angle`, `fixedPoint_mag` and `range_err` update only on the completing edge. They hold their value until the next completion.
- **`start` while `busy`=1:** ignored, with no effect on the state or the operands.

## Timing
- **Reset:** when `reset`=0 at an edge (regardless of `clk_en`):
  - the FSM goes to IDLE and the counter to 0;
  - `busy`=0, `done`=0, `range_err`=0, `fixedPoint_angle`=0, `fixedPoint_mag`=0;
  - working registers are set to 0.
  - Reset mid-RUN aborts the operation and no `done` is produced.
- **Accept:** `start`=1, `busy`=0, `clk_en`=1 at edge k. `busy` goes to 1 after edge k.
- **Compute:** enabled edges k+1 … k+N.
  - On edge k+N: results are registered, `done`=1, `busy`=0.
  - `done` is high for exactly one cycle; latency is N+1 enabled edges (4 by default).
- **Back-to-back:** `start` is accepted in the same cycle that `done` is high. The outputs keep the previous results until the new `done`.
- **`clk_en`=0:** all state freezes, including a `done` pulse (it stretches). Operation resumes without loss when `clk_en` returns to 1.

## Test plan
- **Zero angle:** reset low for 2 cycles, then x=0x100000 (0.5), y=0, `start`.
  - `done` arrives exactly 4 edges after accept.
  - angle = 0 ±256 LSB; mag = 1726743 ±256 LSB; `range_err`=0.
- **Positive 45°:** x=y=0x080000 (0.25).
  - angle = 1647099 (π/4) ±256 LSB; mag = 1220993 ±256 LSB.
- **Negative 45°:** x=0x080000, y=−0x080000.
  - angle = −1647099 ±256 LSB; mag = 1220993 ±256 LSB.
  - Repeat back-to-back, with `start` asserted in the `done` cycle: the second `done` follows 4 edges later and the outputs change only then.
- **Negative x:** x=−0x080000, y=0x010000.
  - `done` with `range_err`=1, angle=0, mag=0.
  - A following valid request clears `range_err`.
- **Control interference:**
  - Pulse `start` with different operands while `busy`: the results match the first operands.
  - Hold `clk_en`=0 for 5 cycles mid-RUN: the results are unchanged and `done` is delayed by 5 cycles.
- **Mid-operation reset:** drive `reset`=0 at the second RUN edge.
  - All outputs read 0 and `busy`=0, and no `done` follows.
  - A new request then completes correctly.
